// File: rtl/router_pkt_fifo_pkg.sv
// Shared router FIFO definitions: default sizes, header length field position,
// tagged-entry type and the header length extractor.
package router_pkg;

    localparam int ROUTER_DW         = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int LEN_LSB           = 2;

    typedef struct packed {
        logic                 hdr;
        logic [ROUTER_DW-1:0] data;
    } fifo_entry_t;

    // Caller zero-extends the word; the result is the payload length field.
    function automatic logic [31:0] len_of(input logic [31:0] word);
        return word >> LEN_LSB;
    endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake and status bundle between the router core and one output-port FIFO.
// parity_err exists only when ROUTER_FIFO_PARITY_CHK_EN is defined.
interface router_pkt_fifo_if #(
    parameter int WIDTH = router_pkg::ROUTER_DW,
    parameter int CW    = $clog2(router_pkg::ROUTER_FIFO_DEPTH) + 1
);
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             pkt_active;
`ifdef ROUTER_FIFO_PARITY_CHK_EN
    logic             parity_err;
`endif

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, empty, full, almost_full, count, pkt_active
`ifdef ROUTER_FIFO_PARITY_CHK_EN
        , input parity_err
`endif
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, empty, full, almost_full, count, pkt_active
`ifdef ROUTER_FIFO_PARITY_CHK_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/router_pkt_fifo_mem.sv
// Simple dual-port tagged FIFO storage: synchronous write, registered data read,
// plus a combinational look-ahead of the entry at the read address.
module router_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH:0]   wdata,
    input  logic             re,
    input  logic             clr,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH:0]   head,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH:0] mem [DEPTH];

    // Contents are intentionally never cleared; only pointers are reset.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign head = mem[raddr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)    rdata <= '0;
        else if (clr) rdata <= '0;
        else if (re)  rdata <= head[WIDTH-1:0];
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-port FIFO: occupancy flags, 1-cycle read, remaining-byte tracker.
// Optional parity check on packet tail when ROUTER_FIFO_PARITY_CHK_EN is defined.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int WIDTH     = ROUTER_DW,
    parameter int DEPTH     = ROUTER_FIFO_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            soft_reset,
    router_pkt_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = CW + WIDTH - 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count_q, count_nxt;
    logic             empty_q, full_q, afull_q, pkt_q;
    logic [RW-1:0]    rem_q, rem_nxt;
    logic [WIDTH:0]   head;
    logic [WIDTH-1:0] rdata;
    logic             wr_acc, rd_acc, mem_clr;

    assign wr_acc  = bus.write_enb && !full_q  && !soft_reset;
    assign rd_acc  = bus.read_enb  && !empty_q && !soft_reset;
    // Drive a clean zero once the channel has nothing left to present.
    assign mem_clr = soft_reset || (!rd_acc && empty_q && (rem_q == '0));

    router_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata ({bus.lfd_state, bus.data_in}),
        .re    (rd_acc),
        .clr   (mem_clr),
        .raddr (rptr),
        .head  (head),
        .rdata (rdata)
    );

    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
        else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);
    end

    // Header reload counts payload plus the trailing parity byte.
    always_comb begin
        rem_nxt = rem_q;
        if (rd_acc) begin
            if (head[WIDTH])
                rem_nxt = RW'(len_of(32'(head[WIDTH-1:0])) + 32'd1);
            else if (rem_q != '0)
                rem_nxt = rem_q - RW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            rem_q   <= '0;
            pkt_q   <= 1'b0;
        end else if (soft_reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            rem_q   <= '0;
            pkt_q   <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            if (rd_acc) rptr <= rptr + AW'(1);
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == DEPTH_C);
            afull_q <= (count_nxt >= AFULL_C);
            rem_q   <= rem_nxt;
            pkt_q   <= (rem_nxt != '0);
        end
    end

    assign bus.data_out    = rdata;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;
    assign bus.pkt_active  = pkt_q;

`ifdef ROUTER_FIFO_PARITY_CHK_EN
    logic [WIDTH-1:0] acc_q;
    logic             perr_q;

    // Accumulator covers header and payload; the last word read is the parity byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            perr_q <= 1'b0;
        end else if (soft_reset) begin
            acc_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (rd_acc) begin
                if (head[WIDTH])
                    acc_q <= head[WIDTH-1:0];
                else if (rem_q == RW'(1))
                    perr_q <= (head[WIDTH-1:0] != acc_q);
                else if (rem_q != '0)
                    acc_q <= acc_q ^ head[WIDTH-1:0];
            end
        end
    end

    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;
    import router_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = 5;
    localparam int AF = D - 2;

    typedef struct {
        int cnt;
        int emp;
        int ful;
        int af;
        int pkt;
        int dout;
        int perr;
    } snap_t;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset;

    router_pkt_fifo_if #(.WIDTH(W), .CW(CW)) bus ();

    router_pkt_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_entry_t mq[$];
    int          m_rem  = 0;
    int          m_dout = 0;
    int          m_acc  = 0;
    int          m_perr = 0;
    snap_t       exp_q[$];

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rem  = 0;
        m_dout = 0;
        m_acc  = 0;
        m_perr = 0;
    endfunction

    function automatic snap_t model_step(bit we, bit lfd, logic [7:0] din, bit re, bit sr);
        snap_t       s;
        fifo_entry_t e;
        int          pre;
        if (sr) begin
            model_reset();
        end else begin
            pre    = mq.size();
            m_perr = 0;
            if (re && pre > 0) begin
                e      = mq.pop_front();
                m_dout = int'(e.data);
                if (e.hdr) begin
                    m_rem = (int'(e.data) / 4) + 1;
                    m_acc = int'(e.data);
                end else if (m_rem > 0) begin
                    if (m_rem == 1) m_perr = (int'(e.data) != m_acc) ? 1 : 0;
                    else            m_acc  = m_acc ^ int'(e.data);
                    m_rem--;
                end
            end else if (pre == 0 && m_rem == 0) begin
                m_dout = 0;
            end
            if (we && pre < D) begin
                e.hdr  = lfd;
                e.data = din;
                mq.push_back(e);
            end
        end
        s.cnt  = mq.size();
        s.emp  = (mq.size() == 0) ? 1 : 0;
        s.ful  = (mq.size() == D) ? 1 : 0;
        s.af   = (mq.size() >= AF) ? 1 : 0;
        s.pkt  = (m_rem != 0) ? 1 : 0;
        s.dout = m_dout;
        s.perr = m_perr;
        return s;
    endfunction

    task automatic step(bit we, bit lfd, logic [7:0] din, bit re, bit sr);
        snap_t s;
        bus.write_enb = we;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_enb  = re;
        soft_reset    = sr;
        s = model_step(we, lfd, din, re, sr);
        @(posedge clock);
        exp_q.push_back(s);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && mq.size() > 0; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic send_pkt(logic [7:0] hdr, int n, logic [7:0] pay[], bit good);
        logic [7:0] p;
        p = hdr;
        step(1'b1, 1'b1, hdr, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, pay[k], 1'b0, 1'b0);
            p = p ^ pay[k];
        end
        if (!good) p = p ^ 8'h01;
        step(1'b1, 1'b0, p, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check(string tag);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk({tag, "_empty"}, int'(bus.empty), 1);
        chk({tag, "_full"},  int'(bus.full), 0);
        chk({tag, "_count"}, int'(bus.count), 0);
        chk({tag, "_dout"},  int'(bus.data_out), 0);
        chk({tag, "_pkt"},   int'(bus.pkt_active), 0);
        model_reset();
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        soft_reset    = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #2;
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("count",       int'(bus.count), s.cnt);
                chk("empty",       int'(bus.empty), s.emp);
                chk("full",        int'(bus.full), s.ful);
                chk("almost_full", int'(bus.almost_full), s.af);
                chk("pkt_active",  int'(bus.pkt_active), s.pkt);
                chk("data_out",    int'(bus.data_out), s.dout);
`ifdef ROUTER_FIFO_PARITY_CHK_EN
                chk("parity_err",  int'(bus.parity_err), s.perr);
`endif
            end
        end
    end

    initial begin : driver
        logic [7:0] pay[];
        reset         = 1'b1;
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = 1'b0;
        #1;
        chk("por_empty", int'(bus.empty), 1);
        chk("por_count", int'(bus.count), 0);
        chk("por_dout",  int'(bus.data_out), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;

        // fill, overflow attempt, drain; three passes walk the pointers around
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 1; i <= D; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
            for (int i = 0; i < D; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            idle();
        end

        // async reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        async_reset_check("arst");
        step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // simultaneous read/write at mid level, full and empty
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
        drain();
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        drain();
        step(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
        drain();
        idle();

        // packet tracking, header 0x0C carries three payload bytes
        pay = new[3];
        pay[0] = 8'h31; pay[1] = 8'h32; pay[2] = 8'h33;
        send_pkt(8'h0C, 3, pay, 1'b1);
        drain();
        idle();
        idle();
        // zero-length header is followed only by its parity byte
        pay = new[0];
        send_pkt(8'h00, 0, pay, 1'b1);
        drain();
        idle();

        // soft reset with a packet partially read out and a read in the same cycle
        step(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle();
        step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        drain();
        idle();

`ifdef ROUTER_FIFO_PARITY_CHK_EN
        pay = new[2];
        pay[0] = 8'h11; pay[1] = 8'h22;
        send_pkt(8'h08, 2, pay, 1'b1);
        drain();
        idle();
        send_pkt(8'h08, 2, pay, 1'b0);
        drain();
        idle();
        idle();
`endif

        // randomized traffic, short headers so packets complete often
        for (int i = 0; i < 500; i++) begin
            bit         we, re, lfd, sr;
            logic [7:0] din;
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < 50);
            lfd = ($urandom_range(0, 7) == 0);
            sr  = ($urandom_range(0, 79) == 0);
            din = 8'($urandom);
            if (lfd) din = {3'b000, din[4:0]};
            step(we, lfd, din, re, sr);
        end
        drain();
        idle();
        idle();

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
